// File: rtl/coord_mem_loader.sv
// Write master for the X/Y coordinate memories: accepts (x, y) pairs and writes them at a
// shared sequential address. Optional per-entry readback check under LOADER_READBACK_VERIFY_EN.
module coord_mem_loader #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned MEM_ID_W   = 3,
  parameter int unsigned X_MEM_ID   = 0,
  parameter int unsigned Y_MEM_ID   = 1,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         coord_valid,
  output logic                         coord_ready,
  input  logic [DATA_W-1:0]            x_in,
  input  logic [DATA_W-1:0]            y_in,
  input  logic                         finish,
  output logic [MEM_ID_W-1:0]          mem_id,
  output logic [ADDR_W-1:0]            address,
  output logic [DATA_W-1:0]            data,
  output logic                         wren,
  input  logic [DATA_W-1:0]            mem_q,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         done,
  output logic                         error
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [MEM_ID_W-1:0] X_ID = MEM_ID_W'(X_MEM_ID);
  localparam logic [MEM_ID_W-1:0] Y_ID = MEM_ID_W'(Y_MEM_ID);

`ifdef LOADER_READBACK_VERIFY_EN
  typedef enum logic [2:0] {StIdle, StWrX, StWrY, StRdX, StRdY, StCommit, StDone} state_t;
`else
  typedef enum logic [2:0] {StIdle, StWrX, StWrY, StCommit, StDone} state_t;
`endif

  state_t            state_q, state_d;
  logic [DATA_W-1:0] x_lat_q, x_lat_d;
  logic [DATA_W-1:0] y_lat_q, y_lat_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              finish_pend_q, finish_pend_d;
  logic              accept;

`ifdef LOADER_READBACK_VERIFY_EN
  localparam int unsigned RD_CNT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic                error_q, error_d;
  logic                rd_last;

  // mem_q reflects the RD address only after RD_LATENCY cycles: compare on the last one
  assign rd_last = (rd_cnt_q == RD_CNT_W'(RD_LATENCY));
  assign error   = error_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      error_q  <= error_d;
    end
  end
`else
  logic unused_sig;
  assign unused_sig = ^mem_q ^ (RD_LATENCY != 0);
  assign error      = 1'b0;
`endif

  assign coord_ready = (state_q == StIdle) & ~full_q & ~finish_pend_q;
  assign accept      = coord_valid & coord_ready;
  assign count       = count_q;
  assign full        = full_q;
  assign done        = (state_q == StDone);

  always_comb begin
    state_d       = state_q;
    x_lat_d       = x_lat_q;
    y_lat_d       = y_lat_q;
    count_d       = count_q;
    full_d        = full_q;
    finish_pend_d = finish_pend_q;
`ifdef LOADER_READBACK_VERIFY_EN
    rd_cnt_d      = rd_cnt_q;
    error_d       = error_q;
`endif

    // A finish that cannot be acted on right now is remembered until the entry completes
    if (finish && (state_q != StDone) && ((state_q != StIdle) || accept)) begin
      finish_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          x_lat_d = x_in;
          y_lat_d = y_in;
          state_d = StWrX;
        end else if (finish || finish_pend_q) begin
          state_d = StDone;
        end
      end
      StWrX: state_d = StWrY;
`ifdef LOADER_READBACK_VERIFY_EN
      StWrY: begin
        rd_cnt_d = '0;
        state_d  = StRdX;
      end
      StRdX: begin
        if (rd_last) begin
          if (mem_q != x_lat_q) error_d = 1'b1;
          rd_cnt_d = '0;
          state_d  = StRdY;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      StRdY: begin
        if (rd_last) begin
          if (mem_q != y_lat_q) error_d = 1'b1;
          rd_cnt_d = '0;
          state_d  = StCommit;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
`else
      StWrY: state_d = StCommit;
`endif
      StCommit: begin
        count_d = count_q + 1'b1;
        full_d  = ((count_q + 1'b1) == CNT_W'(DEPTH));
        state_d = StIdle;
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wren    = 1'b0;
    mem_id  = X_ID;
    address = ADDR_W'(count_q);
    data    = '0;
    unique case (state_q)
      StWrX: begin
        wren = 1'b1;
        data = x_lat_q;
      end
      StWrY: begin
        wren   = 1'b1;
        mem_id = Y_ID;
        data   = y_lat_q;
      end
`ifdef LOADER_READBACK_VERIFY_EN
      StRdY: mem_id = Y_ID;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      x_lat_q       <= '0;
      y_lat_q       <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      finish_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_lat_q       <= x_lat_d;
      y_lat_q       <= y_lat_d;
      count_q       <= count_d;
      full_q        <= full_d;
      finish_pend_q <= finish_pend_d;
    end
  end

endmodule
